// File: rtl/tm_netlist_1.sv
// tm_netlist_1: bank of 62 saturating Tsetlin automata; out<k> is the include action of automaton k
//   clk, rst         : clock and synchronous active-high reset (loads every state to MID-1)
//   in0..in61        : per-automaton feedback, 1 = reward toward include, 0 = penalty toward exclude
//   out0..out61      : per-automaton action, 1 = include (state MSB)
module tm_netlist_1 #(
  parameter int STATE_BITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in0, in1, in2, in3, in4, in5, in6, in7, in8, in9,
  input  logic in10, in11, in12, in13, in14, in15, in16, in17, in18, in19,
  input  logic in20, in21, in22, in23, in24, in25, in26, in27, in28, in29,
  input  logic in30, in31, in32, in33, in34, in35, in36, in37, in38, in39,
  input  logic in40, in41, in42, in43, in44, in45, in46, in47, in48, in49,
  input  logic in50, in51, in52, in53, in54, in55, in56, in57, in58, in59,
  input  logic in60, in61,
  output logic out0, out1, out2, out3, out4, out5, out6, out7, out8, out9,
  output logic out10, out11, out12, out13, out14, out15, out16, out17, out18, out19,
  output logic out20, out21, out22, out23, out24, out25, out26, out27, out28, out29,
  output logic out30, out31, out32, out33, out34, out35, out36, out37, out38, out39,
  output logic out40, out41, out42, out43, out44, out45, out46, out47, out48, out49,
  output logic out50, out51, out52, out53, out54, out55, out56, out57, out58, out59,
  output logic out60, out61
);
  localparam int N_TA = 62;
  localparam logic [STATE_BITS-1:0] S_RST = {1'b0, {(STATE_BITS-1){1'b1}}};
  logic [N_TA-1:0] w_in, w_out;
  logic [STATE_BITS-1:0] r_s [N_TA];
  assign w_in = {in61, in60, in59, in58, in57, in56, in55, in54, in53, in52, in51, in50,
                 in49, in48, in47, in46, in45, in44, in43, in42, in41, in40,
                 in39, in38, in37, in36, in35, in34, in33, in32, in31, in30,
                 in29, in28, in27, in26, in25, in24, in23, in22, in21, in20,
                 in19, in18, in17, in16, in15, in14, in13, in12, in11, in10,
                 in9, in8, in7, in6, in5, in4, in3, in2, in1, in0};
  assign {out61, out60, out59, out58, out57, out56, out55, out54, out53, out52, out51, out50,
          out49, out48, out47, out46, out45, out44, out43, out42, out41, out40,
          out39, out38, out37, out36, out35, out34, out33, out32, out31, out30,
          out29, out28, out27, out26, out25, out24, out23, out22, out21, out20,
          out19, out18, out17, out16, out15, out14, out13, out12, out11, out10,
          out9, out8, out7, out6, out5, out4, out3, out2, out1, out0} = w_out;
  for (genvar k = 0; k < N_TA; k++) begin : g_ta
    always_ff @(posedge clk)
      r_s[k] <= rst ? S_RST :
                w_in[k] ? (&r_s[k] ? r_s[k] : r_s[k] + 1'b1) :
                (|r_s[k] ? r_s[k] - 1'b1 : r_s[k]);
    assign w_out[k] = r_s[k][STATE_BITS-1];
  end
endmodule

// File: tb/tb_tm_netlist_1.sv
// tb_tm_netlist_1: directed and random check of tm_netlist_1 against an integer saturating-counter model
module tb_tm_netlist_1;
  localparam int N = 62;
  localparam int SMAX = 7;
  localparam int SMID = 4;
  logic clk = 0;
  logic rst = 0;
  logic [N-1:0] vin = '0;
  logic [N-1:0] vout;
  int m [N];
  bit valid = 0;
  int total = 0;
  int bad = 0;
  logic [N-1:0] all1, even;

  always #5 clk = ~clk;

  tm_netlist_1 dut (
    .clk(clk), .rst(rst),
    .in0(vin[0]), .in1(vin[1]), .in2(vin[2]), .in3(vin[3]), .in4(vin[4]), .in5(vin[5]), .in6(vin[6]), .in7(vin[7]),
    .in8(vin[8]), .in9(vin[9]), .in10(vin[10]), .in11(vin[11]), .in12(vin[12]), .in13(vin[13]), .in14(vin[14]), .in15(vin[15]),
    .in16(vin[16]), .in17(vin[17]), .in18(vin[18]), .in19(vin[19]), .in20(vin[20]), .in21(vin[21]), .in22(vin[22]), .in23(vin[23]),
    .in24(vin[24]), .in25(vin[25]), .in26(vin[26]), .in27(vin[27]), .in28(vin[28]), .in29(vin[29]), .in30(vin[30]), .in31(vin[31]),
    .in32(vin[32]), .in33(vin[33]), .in34(vin[34]), .in35(vin[35]), .in36(vin[36]), .in37(vin[37]), .in38(vin[38]), .in39(vin[39]),
    .in40(vin[40]), .in41(vin[41]), .in42(vin[42]), .in43(vin[43]), .in44(vin[44]), .in45(vin[45]), .in46(vin[46]), .in47(vin[47]),
    .in48(vin[48]), .in49(vin[49]), .in50(vin[50]), .in51(vin[51]), .in52(vin[52]), .in53(vin[53]), .in54(vin[54]), .in55(vin[55]),
    .in56(vin[56]), .in57(vin[57]), .in58(vin[58]), .in59(vin[59]), .in60(vin[60]), .in61(vin[61]),
    .out0(vout[0]), .out1(vout[1]), .out2(vout[2]), .out3(vout[3]), .out4(vout[4]), .out5(vout[5]), .out6(vout[6]), .out7(vout[7]),
    .out8(vout[8]), .out9(vout[9]), .out10(vout[10]), .out11(vout[11]), .out12(vout[12]), .out13(vout[13]), .out14(vout[14]), .out15(vout[15]),
    .out16(vout[16]), .out17(vout[17]), .out18(vout[18]), .out19(vout[19]), .out20(vout[20]), .out21(vout[21]), .out22(vout[22]), .out23(vout[23]),
    .out24(vout[24]), .out25(vout[25]), .out26(vout[26]), .out27(vout[27]), .out28(vout[28]), .out29(vout[29]), .out30(vout[30]), .out31(vout[31]),
    .out32(vout[32]), .out33(vout[33]), .out34(vout[34]), .out35(vout[35]), .out36(vout[36]), .out37(vout[37]), .out38(vout[38]), .out39(vout[39]),
    .out40(vout[40]), .out41(vout[41]), .out42(vout[42]), .out43(vout[43]), .out44(vout[44]), .out45(vout[45]), .out46(vout[46]), .out47(vout[47]),
    .out48(vout[48]), .out49(vout[49]), .out50(vout[50]), .out51(vout[51]), .out52(vout[52]), .out53(vout[53]), .out54(vout[54]), .out55(vout[55]),
    .out56(vout[56]), .out57(vout[57]), .out58(vout[58]), .out59(vout[59]), .out60(vout[60]), .out61(vout[61])
  );

  always @(posedge clk) begin
    if (rst) valid <= 1;
    for (int k = 0; k < N; k++)
      m[k] <= rst ? SMID - 1 : vin[k] ? (m[k] < SMAX ? m[k] + 1 : SMAX) : (m[k] > 0 ? m[k] - 1 : 0);
  end

  function automatic logic [N-1:0] model_out();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (m[k] >= SMID);
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid) begin
      total++;
      if (vout !== model_out()) begin
        bad++;
        $display("FAIL model t=%0t out=%h want=%h", $time, vout, model_out());
      end
    end
  end

  task automatic step(input logic r, input logic [N-1:0] v, input int n);
    repeat (n) begin
      rst = r;
      vin = v;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  initial begin
    all1 = '1;
    even = {31{2'b01}};
    #1;
    step(1, all1, 2);
    chk("reset", vout, '0);
    chki("model_reset", m[17], 3);
    step(1, '0, 1);
    step(0, 62'd1, 1);
    chk("single_reward", vout, 62'd1);
    step(1, '0, 1);
    step(0, 62'd1 << 5, 10);
    chki("model_upper_sat", m[5], 7);
    step(0, '0, 3);
    chk("upper_sat_hold", vout, 62'd1 << 5);
    chki("model_upper_dec", m[5], 4);
    step(0, '0, 1);
    chk("upper_sat_drop", vout, '0);
    step(1, '0, 1);
    step(0, '0, 10);
    chki("model_lower_sat", m[61], 0);
    step(0, 62'd1 << 61, 3);
    chk("lower_sat_hold", vout, '0);
    step(0, 62'd1 << 61, 1);
    chk("lower_sat_rise", vout, 62'd1 << 61);
    step(1, '0, 1);
    step(0, even, 1);
    chk("indep_even", vout, even);
    step(0, ~even, 1);
    chk("indep_inv", vout, '0);
    step(0, all1, 10);
    chk("all_sat", vout, all1);
    step(1, all1, 1);
    chk("mid_reset", vout, '0);
    step(0, all1, 1);
    chk("post_reset", vout, all1);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 39) == 0), {$urandom, $urandom} & ({$urandom, $urandom} | {62{i[5]}}), 1);
    step(0, '0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
